// File: rtl/image_loader_if.sv
// image_loader_if -- memory read port between image_loader and a word-wide memory.
//
// Signals:
//   memReadEn  read strobe, one word per strobed cycle
//   memAddr    word address of the read
//   memData    signed read data, valid the cycle after the strobe
//
// Modports:
//   master  the loader side (drives strobe/address, receives data)
//   slave   the memory side (receives strobe/address, drives data)
interface image_loader_if #(
   parameter int unsigned ADDR_SZ = 16,
   parameter int unsigned DATA_SZ = 16
);
   logic                      memReadEn;
   logic        [ADDR_SZ-1:0] memAddr;
   logic signed [DATA_SZ-1:0] memData;

   modport master (
      output memReadEn,
      output memAddr,
      input  memData
   );

   modport slave (
      input  memReadEn,
      input  memAddr,
      output memData
   );
endinterface

// File: rtl/image_loader.sv
// image_loader -- copies a square image (side*side words) from memory into a local buffer.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-high
//   i_loadEnable  level request; a load starts only from idle
//   i_loadAddr    base word address of the image
//   i_loadSize    image side length; word count = side*side, clamped to MAX_WORDS
//   mem           memory read port (image_loader_if.master)
//   o_loadOut     image buffer, row-major
//   o_loadDone    buffer complete and stable
//
// Optional build macro LOADER_ZERO_FILL_EN: entries at index >= word count are zeroed on the
// start edge of every load. Without it those entries keep whatever they held before.
module image_loader #(
   parameter int unsigned DATA_SZ   = 16,
   parameter int unsigned ADDR_SZ   = 16,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_loadEnable,
   input  logic        [ADDR_SZ-1:0] i_loadAddr,
   input  logic        [DATA_SZ-1:0] i_loadSize,
   image_loader_if.master            mem,
   output logic signed [DATA_SZ-1:0] o_loadOut [0:MAX_WORDS-1],
   output logic                      o_loadDone
);
   localparam int unsigned CNT_W  = $clog2(MAX_WORDS + 1);
   localparam int unsigned IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam int unsigned PROD_W = 2 * DATA_SZ;

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic        [ADDR_SZ-1:0] r_memAddr;   // base + issue count while reading
   logic        [CNT_W-1:0]   r_issueCnt;
   logic        [CNT_W-1:0]   r_writeCnt;
   logic        [CNT_W-1:0]   r_total;
   logic                      r_rdValid;   // memData carries a requested word this cycle
   logic signed [DATA_SZ-1:0] r_buf [0:MAX_WORDS-1];

   logic        [PROD_W-1:0]  w_prod;
   logic        [CNT_W-1:0]   w_total;
   logic                      w_start;
   logic                      w_last_issue;

   // Full-width product so large sides clamp instead of wrapping.
   assign w_prod       = PROD_W'(i_loadSize) * PROD_W'(i_loadSize);
   assign w_total      = (w_prod > PROD_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : w_prod[CNT_W-1:0];
   assign w_start      = (r_state == StIdle) && i_loadEnable;
   assign w_last_issue = (r_issueCnt == (r_total - CNT_W'(1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_loadEnable) begin
               w_state_next = (w_total == '0) ? StDone : StRead;
            end
         end
         StRead: begin
            if (w_last_issue) begin
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            w_state_next = StDone;
         end
         StDone: begin
            if (!i_loadEnable) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_memAddr  <= '0;
         r_issueCnt <= '0;
         r_writeCnt <= '0;
         r_total    <= '0;
         r_rdValid  <= 1'b0;
      end else begin
         r_rdValid <= (r_state == StRead);
         if (w_start) begin
            r_total    <= w_total;
            r_issueCnt <= '0;
            r_writeCnt <= '0;
            // An empty load issues nothing, so the address keeps its last value.
            if (w_total != '0) begin
               r_memAddr <= i_loadAddr;
            end
         end else begin
            if (r_state == StRead) begin
               r_issueCnt <= r_issueCnt + CNT_W'(1);
               // Stop on the final address so it is held after the read burst.
               if (!w_last_issue) begin
                  r_memAddr <= r_memAddr + ADDR_SZ'(1);
               end
            end
            if (r_rdValid) begin
               r_writeCnt <= r_writeCnt + CNT_W'(1);
            end
         end
      end
   end

   // Buffer is never cleared by reset; reset only blocks writes in its own cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_rdValid) begin
            r_buf[r_writeCnt[IDX_W-1:0]] <= mem.memData;
         end
`ifdef LOADER_ZERO_FILL_EN
         if (w_start) begin
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
               if (CNT_W'(i) >= w_total) begin
                  r_buf[i] <= '0;
               end
            end
         end
`else
`endif
      end
   end

   assign mem.memReadEn = (r_state == StRead);
   assign mem.memAddr   = r_memAddr;
   assign o_loadDone    = (r_state == StDone);
   assign o_loadOut     = r_buf;
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader -- directed, table-driven bench for image_loader.
// The memory model returns (address + offset) one cycle after each strobe and a filler value
// otherwise. Build with LOADER_ZERO_FILL_EN defined to check the zero-fill variant.
module tb_image_loader;
   logic               clk = 1'b0;
   logic               reset;
   logic               load_en;
   logic        [15:0] load_addr;
   logic        [15:0] load_size;
   logic signed [15:0] load_out [0:1023];
   logic               load_done;
   logic        [15:0] mem_off;

   int   n_vec = 0;
   int   n_bad = 0;

   logic [15:0] exp_buf   [0:1023];
   bit          exp_known [0:1023];

   typedef struct {
      logic [15:0] size;
      logic [15:0] addr;
      logic [15:0] off;
      int          total;
      int          lat;
      int          drop;  // cycle at which load_en is released (0 = hold until done)
   } vec_t;

   vec_t vecs [9];

   image_loader_if #(.ADDR_SZ(16), .DATA_SZ(16)) mif ();

   image_loader #(.DATA_SZ(16), .ADDR_SZ(16), .MAX_WORDS(1024)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_loadEnable (load_en),
      .i_loadAddr   (load_addr),
      .i_loadSize   (load_size),
      .mem          (mif),
      .o_loadOut    (load_out),
      .o_loadDone   (load_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mif.memReadEn === 1'b1) begin
         mif.memData <= mif.memAddr + mem_off;
      end else begin
         mif.memData <= 16'hDEAD;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic model_zero_fill(input int total);
`ifdef LOADER_ZERO_FILL_EN
      for (int i = total; i < 1024; i++) begin
         exp_buf[i]   = 16'h0000;
         exp_known[i] = 1'b1;
      end
`else
      if (total < 0) $display("negative total");
`endif
   endtask

   // Called at a falling edge; returns at a falling edge with the loader back in idle.
   task automatic run_load(input vec_t v, input string tag);
      int          reads    = 0;
      int          first_rd = 0;
      int          done_cyc = 0;
      int          addr_bad = 0;
      int          buf_bad  = 0;
      logic [15:0] exp_a;
      mem_off   = v.off;
      load_addr = v.addr;
      load_size = v.size;
      load_en   = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 1200; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            load_addr = ~v.addr;  // must be ignored after the start edge
            load_size = 16'd7;
         end
         if (cyc == v.drop) load_en = 1'b0;
         if (mif.memReadEn === 1'b1) begin
            exp_a = v.addr + 16'(reads);
            if (first_rd == 0) first_rd = cyc;
            if (mif.memAddr !== exp_a) addr_bad++;
            reads++;
         end
         if (load_done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      check({tag, "_reads"}, 32'(reads), 32'(v.total));
      check({tag, "_first_rd"}, 32'(first_rd), (v.total > 0) ? 32'd1 : 32'd0);
      check({tag, "_addr_seq_errs"}, 32'(addr_bad), 32'd0);
      check({tag, "_done_latency"}, 32'(done_cyc), 32'(v.lat));
      for (int i = 0; i < v.total; i++) begin
         exp_buf[i]   = v.addr + 16'(i) + v.off;
         exp_known[i] = 1'b1;
      end
      model_zero_fill(v.total);
      for (int i = 0; i < 1024; i++) begin
         if (exp_known[i] && (load_out[i] !== exp_buf[i])) buf_bad++;
      end
      check({tag, "_buf_errs"}, 32'(buf_bad), 32'd0);
      load_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_clear"}, {31'd0, load_done}, 32'd0);
      check({tag, "_rden_idle"}, {31'd0, mif.memReadEn}, 32'd0);
   endtask

   initial begin
      int  bad;
      vec_t hv;

      vecs[0] = '{size: 16'd3,     addr: 16'h0100, off: 16'h0000, total: 9,    lat: 11,   drop: 0};
      vecs[1] = '{size: 16'd0,     addr: 16'h0200, off: 16'h0000, total: 0,    lat: 1,    drop: 0};
      vecs[2] = '{size: 16'd4,     addr: 16'h7000, off: 16'h0010, total: 16,   lat: 18,   drop: 0};
      vecs[3] = '{size: 16'd2,     addr: 16'hFFFE, off: 16'h0020, total: 4,    lat: 6,    drop: 0};
      vecs[4] = '{size: 16'd1,     addr: 16'h0042, off: 16'h0030, total: 1,    lat: 3,    drop: 0};
      vecs[5] = '{size: 16'd3,     addr: 16'h0300, off: 16'h0040, total: 9,    lat: 11,   drop: 3};
      vecs[6] = '{size: 16'd40,    addr: 16'h1000, off: 16'h0000, total: 1024, lat: 1026, drop: 0};
      vecs[7] = '{size: 16'd32,    addr: 16'h2000, off: 16'h0050, total: 1024, lat: 1026, drop: 0};
      vecs[8] = '{size: 16'hFFFF,  addr: 16'h3000, off: 16'h0060, total: 1024, lat: 1026, drop: 0};

      for (int i = 0; i < 1024; i++) exp_known[i] = 1'b0;

      reset     = 1'b1;
      load_en   = 1'b0;
      load_addr = 16'h0000;
      load_size = 16'h0000;
      mem_off   = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rden", {31'd0, mif.memReadEn}, 32'd0);
      check("rst_addr", 32'(mif.memAddr), 32'd0);
      check("rst_done", {31'd0, load_done}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 9; k++) begin
         run_load(vecs[k], $sformatf("v%0d", k));
      end

      // Explicit check of entries 4..15 after a 16-word load followed by a 4-word load.
      hv = '{size: 16'd4, addr: 16'h0400, off: 16'h0100, total: 16, lat: 18, drop: 0};
      run_load(hv, "zf_first");
      hv = '{size: 16'd2, addr: 16'h0800, off: 16'h0000, total: 4, lat: 6, drop: 0};
      run_load(hv, "zf_second");
      bad = 0;
      for (int i = 4; i < 16; i++) begin
`ifdef LOADER_ZERO_FILL_EN
         if (load_out[i] !== 16'h0000) bad++;
`else
         if (load_out[i] !== 16'(16'h0400 + i + 16'h0100)) bad++;
`endif
      end
      check("zf_tail_errs", 32'(bad), 32'd0);

      // Reset during the 5th read of a 16-word load.
      mem_off   = 16'h0700;
      load_addr = 16'h0500;
      load_size = 16'd4;
      load_en   = 1'b1;
      @(posedge clk);
      for (int cyc = 1; cyc <= 5; cyc++) @(negedge clk);
      check("rst_mid_rden_before", {31'd0, mif.memReadEn}, 32'd1);
      reset   = 1'b1;
      load_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_rden", {31'd0, mif.memReadEn}, 32'd0);
      check("rst_mid_done", {31'd0, load_done}, 32'd0);
      check("rst_mid_addr", 32'(mif.memAddr), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_no_late_write", 32'(load_out[4]), 32'(exp_buf[4]));
      for (int i = 0; i < 3; i++) exp_buf[i] = 16'h0500 + 16'(i) + 16'h0700;
      exp_known[3] = 1'b0;
      model_zero_fill(16);
      hv = '{size: 16'd4, addr: 16'h0600, off: 16'h0200, total: 16, lat: 18, drop: 0};
      run_load(hv, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
